// File: rtl/clock_mode_controller.sv
// Mode sequencer for the hh:mm:ss counter chain: button conditioning, run/set FSM,
// tick gating, set-mode increment/auto-repeat strobes and the display blink flag.

module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic level_next
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] count;
    logic          settle;

    // level_next is exposed so the controller reacts on the same edge the level moves
    always_comb begin
        settle     = (sync2 != level) && (count == CW'(DEBOUNCE_CYCLES - 1));
        level_next = settle ? sync2 : level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            count <= '0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            level <= level_next;
            if (sync2 == level || settle)
                count <= '0;
            else
                count <= count + CW'(1);
        end
    end
endmodule

module clock_mode_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 16,
    parameter int BLINK_TICKS     = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_mode_btn_n,
    input  logic       i_inc_btn_n,
    output logic       o_sec_inc,
    output logic       o_sec_clr,
    output logic       o_min_inc,
    output logic       o_hr_inc,
    output logic [1:0] o_mode,
    output logic       o_blink
);
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        SET_SEC = 2'b11
    } mode_t;

    mode_t         state;
    mode_t         state_next;
    logic          mode_level, mode_level_next;
    logic          inc_level, inc_level_next;
    logic          mode_press, inc_press, inc_held, inc_fire;
    logic          setting;
    logic          armed;
    logic [RW-1:0] rep;
    logic [RW-1:0] rep_next;
    logic          rep_fire;
    logic [BW-1:0] blink_cnt;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) mode_db (
        .clk(i_clk), .rst(i_rst), .btn_n(i_mode_btn_n),
        .level(mode_level), .level_next(mode_level_next)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) inc_db (
        .clk(i_clk), .rst(i_rst), .btn_n(i_inc_btn_n),
        .level(inc_level), .level_next(inc_level_next)
    );

    // Repeat only runs for a press that started in the current set state
    always_comb begin
        mode_press = mode_level && !mode_level_next;
        inc_press  = inc_level && !inc_level_next;
        inc_held   = !inc_level_next;
        inc_fire   = inc_press && !mode_press;
        setting    = (state == SET_HR) || (state == SET_MIN);
        state_next = state;
        if (mode_press) begin
            case (state)
                RUN:     state_next = SET_HR;
                SET_HR:  state_next = SET_MIN;
                SET_MIN: state_next = SET_SEC;
                default: state_next = RUN;
            endcase
        end
        rep_next = '0;
        rep_fire = 1'b0;
        if (!mode_press && armed && inc_held && !inc_press && setting) begin
            if (rep == RW'(REPEAT_DELAY + REPEAT_RATE - 1)) begin
                rep_next = RW'(REPEAT_DELAY);
                rep_fire = 1'b1;
            end else begin
                rep_next = rep + RW'(1);
                rep_fire = (rep_next == RW'(REPEAT_DELAY));
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= RUN;
            armed     <= 1'b0;
            rep       <= '0;
            blink_cnt <= '0;
            o_blink   <= 1'b0;
            o_sec_inc <= 1'b0;
            o_sec_clr <= 1'b0;
            o_min_inc <= 1'b0;
            o_hr_inc  <= 1'b0;
        end else begin
            state     <= state_next;
            rep       <= rep_next;
            o_sec_inc <= i_tick && (state_next == RUN);
            o_sec_clr <= inc_fire && (state == SET_SEC);
            o_hr_inc  <= (inc_fire || rep_fire) && (state == SET_HR);
            o_min_inc <= (inc_fire || rep_fire) && (state == SET_MIN);

            if (mode_press || !inc_held)
                armed <= 1'b0;
            else if (inc_press && setting)
                armed <= 1'b1;

            if (state_next == RUN) begin
                o_blink   <= 1'b0;
                blink_cnt <= '0;
            end else if (mode_press) begin
                o_blink   <= 1'b1;
                blink_cnt <= '0;
            end else if (i_tick) begin
                if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
                    o_blink   <= ~o_blink;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

    assign o_mode = state;
endmodule

// File: tb/tb_clock_mode_controller.sv
// Bench for clock_mode_controller: directed scenarios plus randomized button/tick
// traffic, all checked each cycle against a rule-level model of the controller.

module tb_clock_mode_controller;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;
    localparam int BT = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       mode_n = 1'b1;
    logic       inc_n = 1'b1;
    logic       sec_inc, sec_clr, min_inc, hr_inc, blink;
    logic [1:0] mode;

    int check_count = 0;
    int pass_count  = 0;
    int step_no     = 0;
    int n_sec = 0, n_clr = 0, n_min = 0, n_hr = 0;
    int min_steps[$];

    always #5 clk = ~clk;

    clock_mode_controller #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .BLINK_TICKS(BT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_tick(tick),
        .i_mode_btn_n(mode_n), .i_inc_btn_n(inc_n),
        .o_sec_inc(sec_inc), .o_sec_clr(sec_clr), .o_min_inc(min_inc),
        .o_hr_inc(hr_inc), .o_mode(mode), .o_blink(blink)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        step_no++;
        if (sec_inc) n_sec++;
        if (sec_clr) n_clr++;
        if (hr_inc)  n_hr++;
        if (min_inc) begin
            n_min++;
            min_steps.push_back(step_no);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic i, input logic t, input int cycles);
        mode_n = m;
        inc_n  = i;
        tick   = t;
        repeat (cycles) step();
    endtask

    task automatic clear_counts();
        n_sec = 0; n_clr = 0; n_min = 0; n_hr = 0;
        min_steps.delete();
    endtask

    task automatic press_mode();
        applyStimulus(1'b0, 1'b1, 1'b0, 8);
        applyStimulus(1'b1, 1'b1, 1'b0, 12);
    endtask

    // Reference model: debounced level flips once DB consecutive synced samples
    // since the last flip all disagree with it; repeat strobes follow held-cycle arithmetic.
    bit m_valid = 1'b0;
    int m_mode, m_bcnt, held, nmode;
    bit m_blink, armed;
    bit e_sec, e_clr, e_min, e_hr;
    bit sy1[2], sy2[2], lvl[2], new_lvl[2], raw_now[2];
    bit shist[2][DB];
    int since_flip[2];
    bit m_s, all_diff, mpress, ipress, ihold, ifire, rfire, setting;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_mode = 0; m_blink = 1'b0; m_bcnt = 0;
            e_sec = 0; e_clr = 0; e_min = 0; e_hr = 0;
            armed = 1'b0; held = 0;
            for (int b = 0; b < 2; b++) begin
                sy1[b] = 1'b1; sy2[b] = 1'b1; lvl[b] = 1'b1; since_flip[b] = 0;
            end
        end else if (m_valid) begin
            raw_now[0] = mode_n;
            raw_now[1] = inc_n;
            for (int b = 0; b < 2; b++) begin
                m_s = sy2[b];
                sy2[b] = sy1[b];
                sy1[b] = raw_now[b];
                for (int k = DB - 1; k > 0; k--) shist[b][k] = shist[b][k-1];
                shist[b][0] = m_s;
                since_flip[b]++;
                new_lvl[b] = lvl[b];
                if (since_flip[b] >= DB) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < DB; k++) all_diff &= (shist[b][k] != lvl[b]);
                    if (all_diff) begin
                        new_lvl[b] = m_s;
                        since_flip[b] = 0;
                    end
                end
            end
            mpress  = lvl[0] && !new_lvl[0];
            ipress  = lvl[1] && !new_lvl[1];
            ihold   = !new_lvl[1];
            nmode   = mpress ? (m_mode + 1) % 4 : m_mode;
            ifire   = ipress && !mpress;
            setting = (m_mode == 1) || (m_mode == 2);
            rfire   = 1'b0;
            if (!mpress && armed && ihold && !ipress && setting) begin
                held++;
                rfire = (held == RD) || (held > RD && (held - RD) % RR == 0);
            end
            if (mpress || !ihold) begin
                armed = 1'b0; held = 0;
            end else if (ipress && setting) begin
                armed = 1'b1; held = 0;
            end
            e_sec = tick && (nmode == 0);
            e_clr = ifire && (m_mode == 3);
            e_hr  = (m_mode == 1) && (ifire || rfire);
            e_min = (m_mode == 2) && (ifire || rfire);
            if (nmode == 0) begin
                m_blink = 1'b0; m_bcnt = 0;
            end else if (mpress) begin
                m_blink = 1'b1; m_bcnt = 0;
            end else if (tick) begin
                m_bcnt++;
                if (m_bcnt == BT) begin
                    m_blink = !m_blink; m_bcnt = 0;
                end
            end
            m_mode = nmode;
            lvl[0] = new_lvl[0];
            lvl[1] = new_lvl[1];
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model_mode", int'(mode), m_mode);
            checkOutput("model_blink", int'(blink), int'(m_blink));
            checkOutput("model_sec_inc", int'(sec_inc), int'(e_sec));
            checkOutput("model_sec_clr", int'(sec_clr), int'(e_clr));
            checkOutput("model_min_inc", int'(min_inc), int'(e_min));
            checkOutput("model_hr_inc", int'(hr_inc), int'(e_hr));
            checkOutput("strobe_exclusive", int'($countones({sec_inc, sec_clr, min_inc, hr_inc}) <= 1), 1);
        end
    end

    initial begin
        int d1, d4;
        int mlen, ilen;
        $display("[TB] start");
        applyStimulus(1'b1, 1'b1, 1'b0, 3);
        checkOutput("reset_mode", int'(mode), 0);
        checkOutput("reset_blink", int'(blink), 0);
        checkOutput("reset_sec_inc", int'(sec_inc), 0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 2);

        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1);
            checkOutput("run_tick_sec_inc", int'(sec_inc), 1);
            applyStimulus(1'b1, 1'b1, 1'b0, 3);
            checkOutput("run_tick_gap", int'(sec_inc), 0);
        end
        checkOutput("run_mode", int'(mode), 0);

        applyStimulus(1'b0, 1'b1, 1'b0, 2);
        applyStimulus(1'b1, 1'b1, 1'b0, 10);
        checkOutput("glitch_no_mode", int'(mode), 0);

        applyStimulus(1'b0, 1'b1, 1'b0, 5);
        checkOutput("mode_latency_early", int'(mode), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        checkOutput("mode_latency_6", int'(mode), 1);
        checkOutput("set_hr_blink", int'(blink), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4);
        applyStimulus(1'b1, 1'b1, 1'b0, 12);

        clear_counts();
        applyStimulus(1'b1, 1'b0, 1'b0, 8);
        applyStimulus(1'b1, 1'b1, 1'b0, 15);
        checkOutput("hr_single_press", n_hr, 1);

        press_mode();
        checkOutput("to_set_min", int'(mode), 2);
        clear_counts();
        applyStimulus(1'b1, 1'b0, 1'b0, 40);
        applyStimulus(1'b1, 1'b1, 1'b0, 15);
        checkOutput("min_repeat_count", n_min, 5);
        d1 = (min_steps.size() >= 2) ? min_steps[1] - min_steps[0] : -1;
        d4 = (min_steps.size() >= 5) ? min_steps[4] - min_steps[0] : -1;
        checkOutput("min_repeat_first", d1, 20);
        checkOutput("min_repeat_last", d4, 35);

        press_mode();
        checkOutput("to_set_sec", int'(mode), 3);
        clear_counts();
        applyStimulus(1'b1, 1'b0, 1'b0, 8);
        applyStimulus(1'b1, 1'b1, 1'b0, 12);
        checkOutput("sec_clr_once", n_clr, 1);
        checkOutput("sec_no_inc", n_sec, 0);
        checkOutput("sec_blink_on", int'(blink), 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("blink_toggle1", int'(blink), 0);
        checkOutput("set_tick_blocked", int'(sec_inc), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        checkOutput("blink_toggle2", int'(blink), 1);

        press_mode();
        checkOutput("back_to_run", int'(mode), 0);
        checkOutput("run_blink_off", int'(blink), 0);

        press_mode();
        checkOutput("simul_start", int'(mode), 1);
        clear_counts();
        applyStimulus(1'b0, 1'b0, 1'b0, 10);
        applyStimulus(1'b1, 1'b0, 1'b0, 40);
        applyStimulus(1'b1, 1'b1, 1'b0, 12);
        checkOutput("simul_mode_wins", int'(mode), 2);
        checkOutput("simul_no_hr", n_hr, 0);
        checkOutput("held_no_repeat", n_min, 0);

        applyStimulus(1'b1, 1'b0, 1'b0, 30);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("rst_mode", int'(mode), 0);
        checkOutput("rst_strobes_a", int'({sec_inc, sec_clr, min_inc, hr_inc}), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("rst_strobes_b", int'({sec_inc, sec_clr, min_inc, hr_inc}), 0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1);
        checkOutput("rst_strobes_c", int'({sec_inc, sec_clr, min_inc, hr_inc}), 0);
        checkOutput("rst_mode_after", int'(mode), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 12);

        mlen = 10;
        ilen = 10;
        for (int c = 0; c < 4000; c++) begin
            if (--mlen <= 0) begin
                mode_n = ~mode_n;
                mlen = (mode_n == 1'b0) ? $urandom_range(1, 12) : $urandom_range(1, 60);
            end
            if (--ilen <= 0) begin
                inc_n = ~inc_n;
                ilen = $urandom_range(1, 50);
            end
            tick = ($urandom_range(0, 7) == 0);
            rst  = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 5);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
